// File: rtl/bus_grant_mux_pkg.sv
// Shared types and sizing helpers for the bus grant mux and its arbiter.
package bus_grant_mux_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      XFER = 2'd2,
      ACKD = 2'd3
   } bgm_state_e;

   // Owner index width; shared with the round-robin arbiter.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Watchdog counter width; a disabled watchdog still gets one bit.
   function automatic int tmo_width(input int t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction

endpackage

// File: rtl/bus_grant_mux_timeout.sv
// Saturating cycle counter for the transfer watchdog; term flags the last
// allowed cycle so the caller can register its own timeout pulse.
module bus_timeout_counter
   import bus_grant_mux_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic term
);

   localparam int CW = tmo_width(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && (cnt_q != '1))
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign term = (TIMEOUT != 0) && en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/bus_grant_mux.sv
// Latches the arbiter's winner as bus owner for its tenure and routes that
// master's classic transfers onto one shared slave port, with a watchdog.
module bus_grant_mux
   import bus_grant_mux_pkg::*;
#(
   parameter int NUM_PORTS  = 6,
   parameter int SEL_WIDTH  = sel_width(NUM_PORTS),
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS-1:0]             arb_grant,
   input  logic [SEL_WIDTH-1:0]             arb_select,
   input  logic                             arb_active,
   input  logic [NUM_PORTS-1:0]             m_cyc,
   input  logic [NUM_PORTS-1:0]             m_stb,
   input  logic [NUM_PORTS-1:0]             m_we,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  m_adr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  m_dat_w,
   output logic [NUM_PORTS-1:0]             m_ack,
   output logic [NUM_PORTS-1:0]             m_err,
   output logic [DATA_WIDTH-1:0]            m_dat_r,
   output logic                             s_cyc,
   output logic                             s_stb,
   output logic                             s_we,
   output logic [ADDR_WIDTH-1:0]            s_adr,
   output logic [DATA_WIDTH-1:0]            s_dat_w,
   input  logic                             s_ack,
   input  logic                             s_err,
   input  logic [DATA_WIDTH-1:0]            s_dat_r,
   output logic [SEL_WIDTH-1:0]             owner,
   output logic                             busy,
   output logic                             timeout_evt
);

   bgm_state_e                state_q, state_d;
   logic [SEL_WIDTH-1:0]      owner_q, owner_d;
   logic                      s_cyc_q, s_cyc_d, s_stb_q, s_stb_d, s_we_q, s_we_d;
   logic [ADDR_WIDTH-1:0]     s_adr_q, s_adr_d;
   logic [DATA_WIDTH-1:0]     s_dat_w_q, s_dat_w_d, m_dat_r_q, m_dat_r_d;
   logic [NUM_PORTS-1:0]      m_ack_q, m_ack_d, m_err_q, m_err_d;
   logic                      busy_q, busy_d, tmo_evt_q, tmo_evt_d;
   logic                      cnt_clr, cnt_en, tmo_term;

   // A malformed or inconsistent grant is never taken as ownership.
   logic grant_ok;
   assign grant_ok = arb_active && $onehot(arb_grant) &&
                     (int'(arb_select) < NUM_PORTS) && arb_grant[arb_select];

   logic                  own_cyc, own_stb, own_we;
   logic [ADDR_WIDTH-1:0] own_adr;
   logic [DATA_WIDTH-1:0] own_dat;
   logic [NUM_PORTS-1:0]  own_oh;
   assign own_cyc = m_cyc[owner_q];
   assign own_stb = m_stb[owner_q];
   assign own_we  = m_we[owner_q];
   assign own_adr = m_adr[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
   assign own_dat = m_dat_w[owner_q*DATA_WIDTH +: DATA_WIDTH];
   assign own_oh  = NUM_PORTS'(1) << owner_q;

   bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .term (tmo_term)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      s_cyc_d   = s_cyc_q;
      s_stb_d   = s_stb_q;
      s_we_d    = s_we_q;
      s_adr_d   = s_adr_q;
      s_dat_w_d = s_dat_w_q;
      m_dat_r_d = m_dat_r_q;
      m_ack_d   = '0;
      m_err_d   = '0;
      tmo_evt_d = 1'b0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      case (state_q)
         IDLE: if (grant_ok) begin
            owner_d = arb_select;
            s_cyc_d = 1'b1;
            state_d = OWN;
         end
         // Tenure end outranks a fresh strobe.
         OWN: if (!own_cyc) begin
            s_cyc_d = 1'b0;
            owner_d = '0;
            state_d = IDLE;
         end else if (own_stb) begin
            s_we_d    = own_we;
            s_adr_d   = own_adr;
            s_dat_w_d = own_dat;
            s_stb_d   = 1'b1;
            cnt_clr   = 1'b1;
            state_d   = XFER;
         end
         XFER: begin
            cnt_en = 1'b1;
            if (s_err) begin
               m_err_d = own_oh;
               s_stb_d = 1'b0;
               state_d = ACKD;
            end else if (s_ack) begin
               m_ack_d   = own_oh;
               m_dat_r_d = s_dat_r;
               s_stb_d   = 1'b0;
               state_d   = ACKD;
            end else if (tmo_term) begin
               m_err_d   = own_oh;
               tmo_evt_d = 1'b1;
               s_stb_d   = 1'b0;
               state_d   = ACKD;
            end
         end
         // One dead cycle so the master can react to the registered ack.
         ACKD:    state_d = OWN;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         s_cyc_q   <= 1'b0;
         s_stb_q   <= 1'b0;
         s_we_q    <= 1'b0;
         s_adr_q   <= '0;
         s_dat_w_q <= '0;
         m_dat_r_q <= '0;
         m_ack_q   <= '0;
         m_err_q   <= '0;
         busy_q    <= 1'b0;
         tmo_evt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         s_cyc_q   <= s_cyc_d;
         s_stb_q   <= s_stb_d;
         s_we_q    <= s_we_d;
         s_adr_q   <= s_adr_d;
         s_dat_w_q <= s_dat_w_d;
         m_dat_r_q <= m_dat_r_d;
         m_ack_q   <= m_ack_d;
         m_err_q   <= m_err_d;
         busy_q    <= busy_d;
         tmo_evt_q <= tmo_evt_d;
      end
   end

   assign owner       = owner_q;
   assign s_cyc       = s_cyc_q;
   assign s_stb       = s_stb_q;
   assign s_we        = s_we_q;
   assign s_adr       = s_adr_q;
   assign s_dat_w     = s_dat_w_q;
   assign m_dat_r     = m_dat_r_q;
   assign m_ack       = m_ack_q;
   assign m_err       = m_err_q;
   assign busy        = busy_q;
   assign timeout_evt = tmo_evt_q;

endmodule

// File: tb/tb_bus_grant_mux.sv
// Directed scoreboard bench: transfers push expected slave-side and
// master-side responses; independent monitors pop and compare.
module tb_bus_grant_mux;

   localparam int NP = 6;
   localparam int SW = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP-1:0]     arb_grant;
   logic [SW-1:0]     arb_select;
   logic              arb_active;
   logic [NP-1:0]     m_cyc, m_stb, m_we;
   logic [NP*AW-1:0]  m_adr;
   logic [NP*DW-1:0]  m_dat_w;
   logic [NP-1:0]     m_ack, m_err;
   logic [DW-1:0]     m_dat_r;
   logic              s_cyc, s_stb, s_we;
   logic [AW-1:0]     s_adr;
   logic [DW-1:0]     s_dat_w;
   logic              s_ack = 1'b0, s_err = 1'b0;
   logic [DW-1:0]     s_dat_r;
   logic [SW-1:0]     owner;
   logic              busy, timeout_evt;

   bus_grant_mux #(.NUM_PORTS(NP), .SEL_WIDTH(SW), .ADDR_WIDTH(AW),
                   .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .arb_grant(arb_grant), .arb_select(arb_select),
      .arb_active(arb_active), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
      .m_adr(m_adr), .m_dat_w(m_dat_w), .m_ack(m_ack), .m_err(m_err),
      .m_dat_r(m_dat_r), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
      .s_adr(s_adr), .s_dat_w(s_dat_w), .s_ack(s_ack), .s_err(s_err),
      .s_dat_r(s_dat_r), .owner(owner), .busy(busy), .timeout_evt(timeout_evt)
   );

   always #5 clk = ~clk;

   typedef struct { int idx; bit we; logic [AW-1:0] adr; logic [DW-1:0] dat; } sreq_t;
   typedef struct { int idx; bit err; bit to; logic [DW-1:0] dat; } rsp_t;
   sreq_t sq[$];
   rsp_t  rq[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Slave model: mode 0 ack, 1 err, 2 ack+err, 3 never answer.
   int sl_mode = 0;
   int sl_wait = 0;
   int wcnt    = 0;
   always @(negedge clk) begin
      if (s_ack || s_err) begin
         s_ack = 1'b0; s_err = 1'b0; wcnt = 0;
      end else if (s_stb && !rst) begin
         if (wcnt >= sl_wait) begin
            s_ack = (sl_mode == 0 || sl_mode == 2);
            s_err = (sl_mode == 1 || sl_mode == 2);
         end else wcnt++;
      end else wcnt = 0;
   end

   // Slave-side monitor: every new strobe must match the next issued request.
   logic stb_prev = 1'b0;
   always @(negedge clk) begin
      if (s_stb && !stb_prev) begin
         if (sq.size() == 0) chk("s_stb_unexpected", 64'(s_adr), 64'hFFFF_FFFF_FFFF_FFFF);
         else begin
            sreq_t e;
            e = sq.pop_front();
            chk("s_we", 64'(s_we), 64'(e.we));
            chk("s_adr", 64'(s_adr), 64'(e.adr));
            chk("s_dat_w", 64'(s_dat_w), 64'(e.dat));
            chk("owner_at_stb", 64'(owner), 64'(e.idx));
            chk("s_cyc_at_stb", 64'(s_cyc), 64'd1);
         end
      end
      stb_prev = s_stb;
   end

   // Master-side monitor.
   int ack4_cnt = 0;
   always @(negedge clk) begin
      if (!rst && (|m_ack || |m_err || timeout_evt)) begin
         if (m_ack[4]) ack4_cnt++;
         if (rq.size() == 0) chk("rsp_unexpected", {m_ack, m_err}, 64'd0);
         else begin
            rsp_t e;
            logic [NP-1:0] oh;
            e  = rq.pop_front();
            oh = NP'(1) << e.idx;
            chk("m_ack", 64'(m_ack), e.err ? 64'd0 : 64'(oh));
            chk("m_err", 64'(m_err), e.err ? 64'(oh) : 64'd0);
            chk("timeout_evt", 64'(timeout_evt), 64'(e.to));
            if (!e.err) chk("m_dat_r", 64'(m_dat_r), 64'(e.dat));
         end
      end
   end

   bit watch_cyc = 1'b0;
   bit cyc_drop  = 1'b0;
   always @(negedge clk) if (watch_cyc && !s_cyc) cyc_drop = 1'b1;

   task automatic acquire(input int idx);
      m_cyc[idx] = 1'b1;
      arb_grant  = NP'(1) << idx;
      arb_select = SW'(idx);
      arb_active = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("acq_owner", 64'(owner), 64'(idx));
      chk("acq_s_cyc", 64'(s_cyc), 64'd1);
      chk("acq_busy", 64'(busy), 64'd1);
   endtask

   task automatic release_bus(input int idx);
      m_cyc[idx] = 1'b0;
      arb_grant  = '0;
      arb_select = '0;
      arb_active = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rel_busy", 64'(busy), 64'd0);
      chk("rel_s_cyc", 64'(s_cyc), 64'd0);
      chk("rel_owner", 64'(owner), 64'd0);
   endtask

   task automatic xfer(input int idx, input bit we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input int mode, input int wt,
                       input logic [DW-1:0] rd, output int stb_cycles);
      bit done;
      sl_mode = mode; sl_wait = wt; s_dat_r = rd;
      sq.push_back('{idx, we, adr, dat});
      if (mode == 3) rq.push_back('{idx, 1'b1, 1'b1, rd});
      else           rq.push_back('{idx, mode != 0, 1'b0, rd});
      m_we[idx] = we;
      m_adr[idx*AW +: AW] = adr;
      m_dat_w[idx*DW +: DW] = dat;
      m_stb[idx] = 1'b1;
      stb_cycles = 0;
      done = 1'b0;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge clk);
         if (s_stb) stb_cycles++;
         if (m_ack[idx] || m_err[idx]) done = 1'b1;
      end
      if (!done) chk("xfer_hang", 64'd0, 64'd1);
      m_stb[idx] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      int sc;
      int a0;
      bit seen;
      rst = 1'b1; arb_grant = '0; arb_select = '0; arb_active = 1'b0;
      m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0; s_dat_r = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_cyc", 64'(s_cyc), 64'd0);
      chk("rst_s_stb", 64'(s_stb), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_owner", 64'(owner), 64'd0);
      chk("rst_m_ack_err", {m_ack, m_err}, 64'd0);
      chk("rst_m_dat_r", 64'(m_dat_r), 64'd0);
      chk("rst_timeout_evt", 64'(timeout_evt), 64'd0);
      rst = 1'b0;

      // Single write, slave acks after 3 wait cycles.
      acquire(2);
      xfer(2, 1'b1, 32'h1000, 32'hA5A5, 0, 3, 32'h0, sc);
      chk("write_stb_cycles", 64'(sc), 64'd4);
      release_bus(2);

      // Read with data.
      acquire(0);
      xfer(0, 1'b0, 32'h20, 32'h0, 0, 1, 32'hDEADBEEF, sc);
      release_bus(0);
      chk("m_dat_r_hold", 64'(m_dat_r), 64'hDEADBEEF);

      // Back-to-back reads in one tenure, zero-wait slave.
      acquire(4);
      a0 = ack4_cnt;
      watch_cyc = 1'b1; cyc_drop = 1'b0;
      xfer(4, 1'b0, 32'h40, 32'h0, 0, 0, 32'h1111_0001, sc);
      chk("b2b_stb_cycles", 64'(sc), 64'd1);
      xfer(4, 1'b0, 32'h44, 32'h0, 0, 0, 32'h1111_0002, sc);
      xfer(4, 1'b0, 32'h48, 32'h0, 0, 0, 32'h1111_0003, sc);
      repeat (4) @(negedge clk);
      watch_cyc = 1'b0;
      chk("b2b_s_cyc_steady", 64'(cyc_drop), 64'd0);
      chk("b2b_ack_count", 64'(ack4_cnt - a0), 64'd3);
      release_bus(4);

      // Watchdog: slave never answers.
      acquire(5);
      xfer(5, 1'b1, 32'h50, 32'h5555, 3, 0, 32'h0, sc);
      chk("timeout_stb_cycles", 64'(sc), 64'd8);
      chk("timeout_s_stb_low", 64'(s_stb), 64'd0);
      release_bus(5);

      // Contention: masters 1 and 3, serviced in grant order.
      m_cyc[1] = 1'b1; m_cyc[3] = 1'b1;
      acquire(1);
      xfer(1, 1'b1, 32'h300, 32'h11, 0, 0, 32'h1111, sc);
      release_bus(1);
      acquire(3);
      xfer(3, 1'b0, 32'h400, 32'h0, 2, 1, 32'h2222, sc);
      release_bus(3);
      chk("contend_m_dat_r", 64'(m_dat_r), 64'h1111);

      // Reset mid-transfer.
      acquire(0);
      sl_mode = 3;
      sq.push_back('{0, 1'b1, 32'h600, 32'h66});
      m_we[0] = 1'b1; m_adr[0 +: AW] = 32'h600; m_dat_w[0 +: DW] = 32'h66; m_stb[0] = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         if (s_stb) seen = 1'b1;
      end
      chk("rst_xfer_started", 64'(seen), 64'd1);
      rst = 1'b1;
      arb_grant = '0; arb_active = 1'b0; arb_select = '0;
      m_stb[0] = 1'b0; m_cyc[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_s_cyc_stb", {s_cyc, s_stb}, 64'd0);
      chk("mid_rst_busy_owner", {busy, owner}, 64'd0);
      chk("mid_rst_ack_err", {m_ack, m_err, timeout_evt}, 64'd0);
      chk("mid_rst_m_dat_r", 64'(m_dat_r), 64'd0);
      chk("mid_rst_s_adr", 64'(s_adr), 64'd0);
      rst = 1'b0;

      // Malformed grants are ignored.
      m_cyc[1] = 1'b1; m_cyc[2] = 1'b1;
      arb_grant = 6'b000110; arb_select = 3'd1; arb_active = 1'b1;
      repeat (3) @(negedge clk);
      chk("bad_grant_multi_busy", {busy, s_cyc}, 64'd0);
      arb_grant = 6'b000100; arb_select = 3'd1;
      repeat (3) @(negedge clk);
      chk("bad_grant_sel_busy", {busy, s_cyc}, 64'd0);
      arb_grant = '0; arb_active = 1'b0; arb_select = '0;
      m_cyc = '0;
      repeat (2) @(negedge clk);

      chk("sq_drained", 64'(sq.size()), 64'd0);
      chk("rq_drained", 64'(rq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
